// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers, parameter checks and status struct for sync_fifo_ctrl
package sync_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit levels_ok(input int depth, input int afull_lvl, input int aempty_lvl);
        return (afull_lvl >= 1) && (afull_lvl <= depth) &&
               (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
    endfunction

    typedef struct packed {
        logic wfull;
        logic rempty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - WIDTH x DEPTH simple dual-port store; SYNC_FIFO_FWFT_EN selects a combinational read port
module sync_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always visible; the read strobe only moves the pointer upstream.
    assign rdata = mem[raddr];

    logic unused_rd;
    assign unused_rd = &{1'b0, reset, re};
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with level flags, sticky errors and flush; SYNC_FIFO_FWFT_EN enables first-word-fall-through
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     wfull,
    input  logic                     read,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     rempty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_ctrl: WIDTH must be >= 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
    end
    if (!levels_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_levels
        $error("sync_fifo_ctrl: AFULL_LVL or AEMPTY_LVL out of range");
    end

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_err;
    logic          rd_err;

    // Acceptance is judged on pre-edge status, so a read cannot make room for a same-cycle write.
    assign wr_acc = write && !wfull  && !flush;
    assign rd_acc = read  && !rempty && !flush;
    assign wr_err = write && wfull   && !flush;
    assign rd_err = read  && rempty  && !flush;

    assign wfull        = (count == PW'(DEPTH));
    assign rempty       = (count == '0);
    assign almost_full  = (count >= PW'(AFULL_LVL));
    assign almost_empty = (count <= PW'(AEMPTY_LVL));

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + PW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_err || (overflow  && !clr_err);
            underflow <= rd_err || (underflow && !clr_err);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rvalid = !rempty;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
        end
    end
`endif

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule
